// File: rtl/cell_ram_arbiter_if.sv
// Request/return and RAM command bundle for the cell RAM arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface cell_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 3
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              ant_req;
    logic              ant_we;
    logic [ADDR_W-1:0] ant_addr;
    logic [DATA_W-1:0] ant_wdata;
    logic              ant_gnt;
    logic              ant_rvalid;
    logic [DATA_W-1:0] ant_rdata;
    logic              ant_starved;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, ant_req, ant_we, ant_addr, ant_wdata, ram_rdata,
        output disp_valid, disp_data, ant_gnt, ant_rvalid, ant_rdata, ant_starved,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, ant_req, ant_we, ant_addr, ant_wdata, ram_rdata,
        input  disp_valid, disp_data, ant_gnt, ant_rvalid, ant_rdata, ant_starved,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/cell_ram_arbiter.sv
// Fixed-priority (display > ant) arbiter for one single-port cell RAM, with owner-tagged returns.
// Optional CELL_ARB_STATS_EN adds ant grant/stall counters with synchronous clear.
module cell_ram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 3,
    parameter int CNT_W     = 8,
    parameter int STARVE_TH = 200
) (
    input  logic clk,
    input  logic rst_n,
    cell_ram_arbiter_if.slave bus
`ifdef CELL_ARB_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_ant_grants,
    output logic [31:0] stat_ant_stall
`endif
);
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_ANT_RD} tag_e;

    localparam logic [CNT_W-1:0] TH = CNT_W'(STARVE_TH);

    logic              gnt;
    logic              stall;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    tag_e              tag_d;
    tag_e              tag_pipe_q [2];
    logic              disp_valid_q, ant_rvalid_q;
    logic [DATA_W-1:0] disp_data_q, ant_rdata_q;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              starved_q;

    assign gnt   = ~bus.disp_req & bus.ant_req;
    assign stall = bus.ant_req & ~gnt;

    // Idle slots keep the address stable so the RAM sees no spurious toggling.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag_d       = TAG_NONE;
        if (bus.disp_req) begin
            ram_addr_d = bus.disp_addr;
            tag_d      = TAG_DISP;
        end else if (gnt) begin
            ram_addr_d  = bus.ant_addr;
            ram_we_d    = bus.ant_we;
            ram_wdata_d = bus.ant_wdata;
            tag_d       = bus.ant_we ? TAG_NONE : TAG_ANT_RD;
        end
    end

    always_comb begin
        wait_d = '0;
        if (stall)
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            tag_pipe_q[0] <= TAG_NONE;
            tag_pipe_q[1] <= TAG_NONE;
            disp_valid_q  <= 1'b0;
            disp_data_q   <= '0;
            ant_rvalid_q  <= 1'b0;
            ant_rdata_q   <= '0;
            wait_q        <= '0;
            starved_q     <= 1'b0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            tag_pipe_q[0] <= tag_d;
            tag_pipe_q[1] <= tag_pipe_q[0];
            // Stage 1 tag lines up with ram_rdata; the other owner's data holds.
            disp_valid_q  <= (tag_pipe_q[1] == TAG_DISP);
            ant_rvalid_q  <= (tag_pipe_q[1] == TAG_ANT_RD);
            if (tag_pipe_q[1] == TAG_DISP)   disp_data_q <= bus.ram_rdata;
            if (tag_pipe_q[1] == TAG_ANT_RD) ant_rdata_q <= bus.ram_rdata;
            wait_q        <= wait_d;
            starved_q     <= (wait_q >= TH);
        end
    end

    assign bus.ant_gnt     = gnt;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.ant_rvalid  = ant_rvalid_q;
    assign bus.ant_rdata   = ant_rdata_q;
    assign bus.ant_starved = starved_q;

`ifdef CELL_ARB_STATS_EN
    logic [31:0] grants_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q    <= '0;
            stall_cnt_q <= '0;
        end else if (stat_clr) begin
            grants_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (gnt)   grants_q    <= grants_q + 32'd1;
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_ant_grants = grants_q;
    assign stat_ant_stall  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_cell_ram_arbiter.sv
// Bench for cell_ram_arbiter: RAM model, shadow memory and per-owner return scoreboards.
module tb_cell_ram_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 3;

    typedef struct {
        int              due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   errors = 0;
    int   checks = 0;
    exp_t dq[$];
    exp_t aq[$];
    logic [DATA_W-1:0] model [4096];
    logic [DATA_W-1:0] mem [4096];
    bit   pre_done = 1'b0;

    always #5 clk = ~clk;

    cell_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

`ifdef CELL_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_ant_grants, stat_ant_stall;
`endif

    cell_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(8), .STARVE_TH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CELL_ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_ant_grants (stat_ant_grants),
        .stat_ant_stall  (stat_ant_stall)
`endif
    );

    function automatic logic [DATA_W-1:0] init_val(int a);
        logic [ADDR_W-1:0] av;
        av = ADDR_W'(a);
        return (a < 4) ? 3'd4 : av[2:0];
    endfunction

    // Write-first synchronous RAM, preloaded on its first clock.
    always @(posedge clk) begin
        if (!pre_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            pre_done <= 1'b1;
            bus.ram_rdata <= '0;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= bus.ram_we ? bus.ram_wdata : mem[bus.ram_addr];
        end
    end

    // Scoreboard compare at mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.disp_valid === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL disp_unexpected cyc=%0d data=%0d expected no valid", cyc, bus.disp_data);
            end else begin
                e = dq.pop_front();
                if (bus.disp_data !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL disp_return cyc=%0d data=%0d expected cyc=%0d data=%0d", cyc, bus.disp_data, e.due, e.data);
                end
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL disp_missing cyc=%0d valid=%b expected pulse", cyc, bus.disp_valid);
            void'(dq.pop_front());
        end
        if (bus.ant_rvalid === 1'b1) begin
            checks++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL ant_unexpected cyc=%0d data=%0d expected no valid", cyc, bus.ant_rdata);
            end else begin
                e = aq.pop_front();
                if (bus.ant_rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL ant_return cyc=%0d data=%0d expected cyc=%0d data=%0d", cyc, bus.ant_rdata, e.due, e.data);
                end
            end
        end else if (aq.size() > 0 && aq[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL ant_missing cyc=%0d valid=%b expected pulse", cyc, bus.ant_rvalid);
            void'(aq.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_outputs_zero(string name);
        logic [31:0] v;
        v = {bus.disp_valid, bus.disp_data, bus.ant_rvalid, bus.ant_rdata,
             bus.ant_starved, bus.ram_we, bus.ram_wdata, bus.ant_gnt};
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs=%h expected 0", name, v);
        end
        checks++;
        if (bus.ram_addr !== '0) begin
            errors++;
            $display("FAIL %s ram_addr=%h expected 0", name, bus.ram_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.ant_req = 0; bus.ant_we = 0; bus.ant_addr = '0; bus.ant_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        cyc = 0;
        repeat (2) tick();
    endtask

    task automatic test_disp_burst();
        for (int i = 0; i < 4; i++) begin
            bus.disp_req = 1; bus.disp_addr = ADDR_W'(i);
            dq.push_back('{cyc + 3, model[i]});
            tick();
        end
        bus.disp_req = 0;
        repeat (6) tick();
    endtask

    task automatic test_ant_write_read();
        bus.ant_req = 1; bus.ant_we = 1; bus.ant_addr = 12'h0A5; bus.ant_wdata = 3'd1;
        #1;
        checks++;
        if (bus.ant_gnt !== 1'b1) begin
            errors++; $display("FAIL ant_wr_gnt gnt=%b expected 1", bus.ant_gnt);
        end
        model[12'h0A5] = 3'd1;
        tick();
        checks++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 12'h0A5, 3'd1}) begin
            errors++;
            $display("FAIL ant_wr_cmd we=%b addr=%h wdata=%0d expected we=1 addr=0a5 wdata=1", bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.ant_we = 0;
        #1;
        checks++;
        if (bus.ant_gnt !== 1'b1) begin
            errors++; $display("FAIL ant_rd_gnt gnt=%b expected 1", bus.ant_gnt);
        end
        aq.push_back('{cyc + 3, model[12'h0A5]});
        tick();
        bus.ant_req = 0;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h0A5) begin
            errors++; $display("FAIL ant_rd_cmd we=%b addr=%h expected we=0 addr=0a5", bus.ram_we, bus.ram_addr);
        end
        repeat (6) tick();
    endtask

    task automatic test_priority();
        logic [ADDR_W-1:0] prev;
        bus.ant_req = 1; bus.ant_we = 0; bus.ant_addr = 12'h013;
        for (int k = 0; k < 10; k++) begin
            bus.disp_req = 1; bus.disp_addr = ADDR_W'(100 + k);
            #1;
            checks++;
            if (bus.ant_gnt !== 1'b0) begin
                errors++; $display("FAIL prio_gnt k=%0d gnt=%b expected 0", k, bus.ant_gnt);
            end
            if (k > 0) begin
                checks++;
                if (bus.ram_addr !== prev) begin
                    errors++; $display("FAIL prio_slot k=%0d ram_addr=%h expected %h", k, bus.ram_addr, prev);
                end
            end
            dq.push_back('{cyc + 3, model[100 + k]});
            prev = bus.disp_addr;
            tick();
        end
        bus.disp_req = 0;
        #1;
        checks++;
        if (bus.ant_gnt !== 1'b1 || bus.ram_addr !== prev) begin
            errors++; $display("FAIL prio_release gnt=%b ram_addr=%h expected gnt=1 addr=%h", bus.ant_gnt, bus.ram_addr, prev);
        end
        aq.push_back('{cyc + 3, model[12'h013]});
        tick();
        bus.ant_req = 0;
        checks++;
        if (bus.ram_addr !== 12'h013 || bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL prio_ant_slot ram_addr=%h we=%b expected 013 we=0", bus.ram_addr, bus.ram_we);
        end
        repeat (8) tick();
    endtask

    task automatic test_starve();
        bus.ant_req = 1; bus.ant_we = 0; bus.ant_addr = 12'h02E;
        for (int k = 1; k <= 10; k++) begin
            bus.disp_req = (k <= 7);
            bus.disp_addr = ADDR_W'(200 + k);
            if (k == 9) bus.ant_req = 0;
            #1;
            checks++;
            if (bus.ant_starved !== (k >= 7 && k <= 9)) begin
                errors++; $display("FAIL starve k=%0d starved=%b expected %b", k, bus.ant_starved, (k >= 7 && k <= 9));
            end
            if (k <= 7) dq.push_back('{cyc + 3, model[200 + k]});
            if (k == 8) begin
                checks++;
                if (bus.ant_gnt !== 1'b1) begin
                    errors++; $display("FAIL starve_gnt gnt=%b expected 1", bus.ant_gnt);
                end
                aq.push_back('{cyc + 3, model[12'h02E]});
            end
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.disp_req = 1; bus.disp_addr = 12'd5;
        tick();
        bus.disp_addr = 12'd6;
        tick();
        bus.disp_req = 0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            if (bus.disp_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_valid pulses=%0d expected 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = init_val(i);
        cyc = 0;
        test_reset();
        test_disp_burst();
        test_ant_write_read();
        test_priority();
        test_starve();
        test_reset_mid();
        checks++;
        if (dq.size() != 0 || aq.size() != 0) begin
            errors++; $display("FAIL drain disp_left=%0d ant_left=%0d expected 0", dq.size(), aq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cell_ram_arbiter.md
Name: cell_ram_arbiter

Overview:
- Shares one single-port synchronous cell RAM between two requesters: the display fetch path and the ant step engine.
- The display fetch path reads 3-bit cell codes that feed the colour mapper. The ant step engine reads and writes cell codes.
- Fixed priority: display first, ant second. The block registers the RAM command, tags each read with its owner, and routes returned data back to that owner.
- A starvation monitor reports when the ant engine is being held off.

Parameters:
- ADDR_W, 12, cell address width (64x64 grid).
- DATA_W, 3, cell code width (matches the colour mapper input).
- CNT_W, 8, width of the ant wait counter.
- STARVE_TH, 200, wait-count threshold at which ant_starved asserts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request for the current cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  display read data valid, one-cycle pulse.
- disp_data  out  DATA_W  display read data.
- ant_req  in  1  ant access request; held until granted.
- ant_we  in  1  1 = write, 0 = read.
- ant_addr  in  ADDR_W  ant address.
- ant_wdata  in  DATA_W  ant write data.
- ant_gnt  out  1  combinational grant; request is accepted this cycle.
- ant_rvalid  out  1  ant read data valid, one-cycle pulse.
- ant_rdata  out  DATA_W  ant read data.
- ant_starved  out  1  ant wait count >= STARVE_TH.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr is presented.

Behaviour:
- Reset values (async, rst_n=0): every output is 0, the wait counter is 0, and the return tag pipeline is cleared.
- Arbitration in cycle N:
  - disp_req=1: display wins, ant_gnt=0.
  - disp_req=0: ant_gnt=ant_req.
  - Both idle: an issue slot is IDLE.
- Issue stage: at the edge ending cycle N, the winner's command is registered onto ram_addr/ram_we/ram_wdata for cycle N+1.
  - IDLE slot: ram_we=0 and ram_addr holds its previous value.
  - ram_we is 1 only for a granted ant write.
- Owner tag pipeline, 2 stages: {NONE, DISP, ANT_RD}. A granted ant write is tagged NONE.
- Return:
  - ram_rdata is valid during cycle N+2.
  - It is registered into disp_data or ant_rdata with the matching valid pulse during cycle N+3, so read latency is 3 cycles from request.
  - The data output of the other owner holds its last value.
- Throughput: one access per cycle. Back-to-back display reads are fully pipelined.
- Ant requester rule: hold ant_req/ant_we/ant_addr/ant_wdata stable until ant_gnt=1. The engine may issue its next request in the cycle after the grant.
- Read-after-write to the same address, ant write granted at N and ant read granted at N+1 or later: the read returns the new data (the RAM is write-first per slot; the arbiter never reorders).
- Wait counter:
  - Increments each cycle with ant_req=1 and ant_gnt=0, saturating at 2^CNT_W-1.
  - Clears to 0 on any cycle with ant_gnt=1 or ant_req=0.
  - ant_starved is a registered compare, counter >= STARVE_TH, and updates one cycle after the counter.
- Reset mid-operation: in-flight tags are discarded and no valid pulses appear after rst_n deasserts until new requests are issued.
- Display is never stalled. The ant engine guarantees forward progress by stepping only during display blanking (disp_req=0).

Optional Feature:
- Macro: CELL_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_ant_grants (32-bit, increments per ant grant) and stat_ant_stall (32-bit, increments per cycle with ant_req=1 and ant_gnt=0).
  - Both wrap at 2^32 and reset to 0.
  - Adds input stat_clr, a synchronous clear; if it coincides with an increment event, the counter becomes 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then display reads from addresses 0..3 on consecutive cycles with RAM preloaded to code 4 at 0..3 -> disp_valid high for 4 consecutive cycles starting 3 cycles after the first request, disp_data=4 each cycle.
- Ant write to address 0x0A5 with data 1 when disp_req=0 -> ant_gnt=1 the same cycle, ram_we=1 with ram_addr=0x0A5 the next cycle, no ant_rvalid.
- Ant read of 0x0A5 the cycle after that write -> ant_rvalid 3 cycles later with ant_rdata=1.
- disp_req and ant_req both held high for 10 cycles, then disp_req drops -> ant_gnt=0 for 10 cycles, then 1 in cycle 11; no RAM command slot lost.
- STARVE_TH=5 with ant_req held and disp_req held for 7 cycles -> ant_starved rises after the counter reaches 5 (one cycle later), and clears the cycle after the counter clears once ant_gnt=1.
- Assert rst_n=0 with 2 display reads in flight -> all outputs 0 immediately, and no disp_valid after rst_n returns to 1.
